// File: rtl/spi_wb_seq.sv
// Wishbone master sequencer: one stream command -> TX, SS, CTRL+GO, completion wait, RX read, response.
// Optional macro SPI_WB_SEQ_IRQ_EN: wait on wb_int_in instead of polling CTRL.GO.
module spi_wb_seq #(
  parameter logic        TX_NEGEDGE = 1'b1,
  parameter logic        RX_NEGEDGE = 1'b0,
  parameter logic        LSB        = 1'b0,
  parameter logic        ASS        = 1'b1,
  parameter logic [15:0] POLL_LIMIT = 16'hFFFF
) (
  input  logic        wb_clk_in,
  input  logic        wb_rst_n_in,
  input  logic        cmd_valid_in,
  output logic        cmd_ready_out,
  input  logic [31:0] cmd_data_in,
  input  logic [6:0]  cmd_len_in,
  input  logic [7:0]  cmd_ss_in,
  output logic        rsp_valid_out,
  input  logic        rsp_ready_in,
  output logic [31:0] rsp_data_out,
  output logic        rsp_err_out,
  output logic [4:0]  wb_adr_out,
  output logic [31:0] wb_dat_out,
  input  logic [31:0] wb_dat_in,
  output logic [3:0]  wb_sel_out,
  output logic        wb_we_out,
  output logic        wb_stb_out,
  output logic        wb_cyc_out,
  input  logic        wb_ack_in,
  input  logic        wb_int_in,
  output logic        busy_out
);

  localparam logic [4:0] ADR_TXRX = 5'h00;
  localparam logic [4:0] ADR_CTRL = 5'h10;
  localparam logic [4:0] ADR_SS   = 5'h18;

`ifdef SPI_WB_SEQ_IRQ_EN
  localparam logic IE = 1'b1;
`else
  localparam logic IE = 1'b0;
  logic unused_int;
  assign unused_int = wb_int_in;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_WR_TX, S_WR_SS, S_WR_CTRL, S_WAIT, S_RD_RX, S_RSP
  } state_t;

  state_t      state, state_next;
  logic [31:0] data_q, data_d;
  logic [6:0]  len_q, len_d;
  logic [7:0]  ss_q, ss_d;
  logic [15:0] cnt_q, cnt_d;

  logic        cyc_d, we_d, rsp_valid_d, rsp_err_d, cmd_ready_d, busy_d;
  logic [4:0]  adr_d;
  logic [3:0]  sel_d;
  logic [31:0] dat_d, rsp_data_d;

  logic        bus_state, req_we;
  logic [4:0]  req_adr;
  logic [3:0]  req_sel;
  logic [31:0] req_dat;
  logic        acked, timeout;

  // An ack only counts while a cycle is in flight
  assign acked   = wb_cyc_out & wb_ack_in;
  assign timeout = (state == S_WAIT) && (16'(cnt_q + 16'd1) == POLL_LIMIT);

  // Fixed bus request for each bus-issuing state
  always_comb begin
    bus_state = 1'b0;
    req_adr   = 5'd0;
    req_we    = 1'b0;
    req_sel   = 4'd0;
    req_dat   = 32'd0;
    case (state)
      S_WR_TX:   begin bus_state = 1'b1; req_adr = ADR_TXRX; req_we = 1'b1; req_sel = 4'hF; req_dat = data_q; end
      S_WR_SS:   begin bus_state = 1'b1; req_adr = ADR_SS;   req_we = 1'b1; req_sel = 4'h1; req_dat = {24'd0, ss_q}; end
      S_WR_CTRL: begin
        bus_state = 1'b1; req_adr = ADR_CTRL; req_we = 1'b1; req_sel = 4'h3;
        req_dat = {18'd0, ASS, IE, LSB, TX_NEGEDGE, RX_NEGEDGE, 1'b1, 1'b0, len_q};
      end
`ifndef SPI_WB_SEQ_IRQ_EN
      S_WAIT:    begin bus_state = 1'b1; req_adr = ADR_CTRL; req_sel = 4'hF; end
`endif
      S_RD_RX:   begin bus_state = 1'b1; req_adr = ADR_TXRX; req_sel = 4'hF; end
      default:   ;
    endcase
  end

  // State register
  always_ff @(posedge wb_clk_in) begin
    if (!wb_rst_n_in) state <= S_IDLE;
    else              state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (cmd_valid_in) state_next = S_WR_TX;
      S_WR_TX:   if (acked) state_next = S_WR_SS;
      S_WR_SS:   if (acked) state_next = S_WR_CTRL;
      S_WR_CTRL: if (acked) state_next = S_WAIT;
      S_WAIT: begin
        if (timeout) state_next = S_RSP;
`ifdef SPI_WB_SEQ_IRQ_EN
        else if (wb_int_in) state_next = S_RD_RX;
`else
        else if (acked && !wb_dat_in[8]) state_next = S_RD_RX;
`endif
      end
      S_RD_RX:   if (acked) state_next = S_RSP;
      S_RSP:     if (rsp_ready_in) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Next values of all registered outputs and datapath
  always_comb begin
    cyc_d       = 1'b0;
    adr_d       = 5'd0;
    we_d        = 1'b0;
    sel_d       = 4'd0;
    dat_d       = 32'd0;
    rsp_valid_d = rsp_valid_out;
    rsp_data_d  = rsp_data_out;
    rsp_err_d   = rsp_err_out;
    data_d      = data_q;
    len_d       = len_q;
    ss_d        = ss_q;
    cnt_d       = cnt_q;
    cmd_ready_d = (state_next == S_IDLE);
    busy_d      = (state_next != S_IDLE);

    // Start or hold the access; the cycle after an ack is always idle
    if (bus_state && !timeout && !acked) begin
      cyc_d = 1'b1;
      adr_d = req_adr;
      we_d  = req_we;
      sel_d = req_sel;
      dat_d = req_dat;
    end

    if (state == S_IDLE && cmd_valid_in) begin
      data_d = cmd_data_in;
      len_d  = cmd_len_in;
      ss_d   = cmd_ss_in;
    end

    if (state == S_WR_CTRL)   cnt_d = 16'd0;
    else if (state == S_WAIT) cnt_d = 16'(cnt_q + 16'd1);

    if (timeout) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
      rsp_data_d  = 32'd0;
    end else if (state == S_RD_RX && acked) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b0;
      rsp_data_d  = wb_dat_in;
    end else if (state == S_RSP && rsp_ready_in) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Output and datapath registers
  always_ff @(posedge wb_clk_in) begin
    if (!wb_rst_n_in) begin
      cmd_ready_out <= 1'b1;
      busy_out      <= 1'b0;
      rsp_valid_out <= 1'b0;
      rsp_err_out   <= 1'b0;
      rsp_data_out  <= 32'd0;
      wb_cyc_out    <= 1'b0;
      wb_stb_out    <= 1'b0;
      wb_we_out     <= 1'b0;
      wb_sel_out    <= 4'd0;
      wb_adr_out    <= 5'd0;
      wb_dat_out    <= 32'd0;
      cnt_q         <= 16'd0;
      data_q        <= 32'd0;
      len_q         <= 7'd0;
      ss_q          <= 8'd0;
    end else begin
      cmd_ready_out <= cmd_ready_d;
      busy_out      <= busy_d;
      rsp_valid_out <= rsp_valid_d;
      rsp_err_out   <= rsp_err_d;
      rsp_data_out  <= rsp_data_d;
      wb_cyc_out    <= cyc_d;
      wb_stb_out    <= cyc_d;
      wb_we_out     <= we_d;
      wb_sel_out    <= sel_d;
      wb_adr_out    <= adr_d;
      wb_dat_out    <= dat_d;
      cnt_q         <= cnt_d;
      data_q        <= data_d;
      len_q         <= len_d;
      ss_q          <= ss_d;
    end
  end

endmodule
